prod_seq_collector: RTL and testbench

Downstream consumer of the 4-phase multiply-select stage. Upstream emits, per 8-bit operand d, the word sequence d, 3d, 7d, 8d on an 11-bit bus, flagging the d word with a one-cycle grant pulse. This block:
- aligns to that sequence and checks each product against the captured d;
- accumulates the four words into one result record;
- buffers records in a small FIFO toward a valid/ready sink.

---
 rtl/prod_seq_collector_if.sv | 28 ++
 rtl/prod_seq_collector.sv | 153 +++++++++++++++
 tb/tb_prod_seq_collector.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/prod_seq_collector_if.sv
// Bus between the multiply-select stage, prod_seq_collector and its record sink.
//   in_grant  : base-word marker from upstream (one-cycle pulse)
//   in_data   : 11-bit upstream product word
//   out_*     : FWFT record head (valid/ready) toward the sink
//   overflow  : sticky record-drop flag
//   desync    : sticky framing-error flag
// master drives the upstream words and out_ready; slave is the collector.
interface prod_seq_collector_if;
  logic        in_grant;
  logic [10:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_base;
  logic [12:0] out_sum;
  logic        out_err;
  logic        overflow;
  logic        desync;

  modport master (
    output in_grant, in_data, out_ready,
    input  out_valid, out_base, out_sum, out_err, overflow, desync
  );

  modport slave (
    input  in_grant, in_data, out_ready,
    output out_valid, out_base, out_sum, out_err, overflow, desync
  );
endinterface

// File: rtl/prod_seq_collector.sv
// prod_seq_collector: aligns to the upstream d, 3d, 7d, 8d word groups, checks
// each product against the captured base, sums the four words and buffers one
// {base, sum, err} record per group in a first-word fall-through FIFO.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : prod_seq_collector_if.slave (upstream words, record sink, flags)
// Parameter:
//   DEPTH : FIFO record entries, power of two, >= 2
module prod_seq_collector #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  prod_seq_collector_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic [7:0]  base;
    logic [12:0] sum;
    logic        err;
  } rec_t;

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  state_t      state;
  logic [1:0]  idx;
  logic [7:0]  base;
  logic [12:0] sum;
  logic        err;
  logic        synced;
  logic        overflow_flag;
  logic        desync_flag;

  rec_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic [10:0] exp_word_c;
  logic [12:0] sum_next_c;
  logic        err_next_c;
  rec_t        rec_c;
  logic        empty_c;
  logic        full_c;
  logic        push_c;
  logic        pop_c;
  logic        drop_c;
  logic        wr_en_c;
  logic [AW-1:0] wr_idx_c;
  logic [AW-1:0] rd_idx_c;

  // Expected product for the pending phase, kept to 11 bits like the upstream bus.
  always_comb begin
    exp_word_c = '0;
    case (idx)
      2'd1:    exp_word_c = 11'(base) * 11'd3;
      2'd2:    exp_word_c = 11'(base) * 11'd7;
      default: exp_word_c = {base, 3'b000};
    endcase
  end

  // Accumulation and FIFO control for the word presented this cycle.
  always_comb begin
    sum_next_c = sum + 13'(bus.in_data);
    err_next_c = err | (bus.in_data != exp_word_c);
    rec_c      = '{base: base, sum: sum_next_c, err: err_next_c};
    wr_idx_c   = wr_ptr[AW-1:0];
    rd_idx_c   = rd_ptr[AW-1:0];
    empty_c    = (wr_ptr == rd_ptr);
    full_c     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx_c == rd_idx_c);
    push_c     = (state == COLLECT) && !bus.in_grant && (idx == 2'd3);
    pop_c      = !empty_c && bus.out_ready;
    // A pop in the same cycle frees the slot the push needs.
    drop_c     = push_c && full_c && !pop_c;
    wr_en_c    = push_c && !drop_c;
  end

  // Group framing, accumulation, FIFO pointers and sticky flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      idx           <= 2'd0;
      base          <= '0;
      sum           <= '0;
      err           <= 1'b0;
      synced        <= 1'b0;
      overflow_flag <= 1'b0;
      desync_flag   <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (bus.in_grant) begin
        // A grant always starts a new group; mid-group it abandons the partial one.
        base   <= bus.in_data[7:0];
        sum    <= 13'(bus.in_data);
        err    <= |bus.in_data[10:8];
        idx    <= 2'd1;
        state  <= COLLECT;
        synced <= 1'b1;
        if (state == COLLECT) begin
          desync_flag <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            // Stray words before the first grant are just alignment slack.
            if (synced) begin
              desync_flag <= 1'b1;
            end
          end
          COLLECT: begin
            sum <= sum_next_c;
            err <= err_next_c;
            if (idx == 2'd3) begin
              state <= IDLE;
            end else begin
              idx <= idx + 2'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end

      if (wr_en_c) begin
        mem[wr_idx_c] <= rec_c;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (drop_c) begin
        overflow_flag <= 1'b1;
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  assign bus.out_valid = !empty_c;
  assign bus.out_base  = mem[rd_idx_c].base;
  assign bus.out_sum   = mem[rd_idx_c].sum;
  assign bus.out_err   = mem[rd_idx_c].err;
  assign bus.overflow  = overflow_flag;
  assign bus.desync    = desync_flag;

endmodule

// File: tb/tb_prod_seq_collector.sv
// Scoreboard bench for prod_seq_collector: the stimulus process frames the
// word stream into groups with a queue-based model and pushes expected records;
// a separate monitor compares the FIFO head and flags every cycle.
module tb_prod_seq_collector;

  localparam int unsigned DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  prod_seq_collector_if bus ();

  prod_seq_collector #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int base;
    int sum;
    bit err;
  } rec_t;

  rec_t exp_q[$];
  int   grp[$];
  bit   synced;
  bit   m_ovf;
  bit   m_desync;
  int   m_cnt;
  int   checks;
  int   failures;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Record derived directly from the four words of a group.
  function automatic rec_t make_rec(input int w[$]);
    rec_t r;
    r.base = w[0] % 256;
    r.sum  = (w[0] + w[1] + w[2] + w[3]) % 8192;
    r.err  = (w[0] / 256 != 0) ||
             (w[1] != (3 * r.base) % 2048) ||
             (w[2] != (7 * r.base) % 2048) ||
             (w[3] != (8 * r.base) % 2048);
    return r;
  endfunction

  // Model of what the block does with one sampled word.
  task automatic model_edge(input bit g, input int d, input bit rdy);
    bit   pop;
    bit   have;
    rec_t r;
    pop  = (m_cnt > 0) && rdy;
    have = 1'b0;
    if (g) begin
      if (grp.size() > 0) m_desync = 1'b1;
      grp.delete();
      grp.push_back(d);
      synced = 1'b1;
    end else if (grp.size() > 0) begin
      grp.push_back(d);
      if (grp.size() == 4) begin
        r    = make_rec(grp);
        have = 1'b1;
        grp.delete();
      end
    end else if (synced) begin
      m_desync = 1'b1;
    end
    if (have) begin
      if (m_cnt == int'(DEPTH) && !pop) begin
        m_ovf = 1'b1;
      end else begin
        exp_q.push_back(r);
        m_cnt++;
      end
    end
    if (pop) m_cnt--;
  endtask

  // Present one word for one clock edge, then return to mid-cycle.
  task automatic step(input bit g, input int d, input bit rdy);
    int dm;
    dm = d % 2048;
    bus.in_grant  = g;
    bus.in_data   = 11'(dm);
    bus.out_ready = rdy;
    @(posedge clk);
    model_edge(g, dm, rdy);
    @(negedge clk);
    #1;
  endtask

  function automatic bit pick_rdy(input int rdy);
    if (rdy < 0) return ($urandom_range(0, 3) != 0);
    return rdy[0];
  endfunction

  task automatic group(input int w0, input int w1, input int w2, input int w3,
                       input int rdy);
    step(1'b1, w0, pick_rdy(rdy));
    step(1'b0, w1, pick_rdy(rdy));
    step(1'b0, w2, pick_rdy(rdy));
    step(1'b0, w3, pick_rdy(rdy));
  endtask

  task automatic gaps(input int n, input int rdy);
    for (int i = 0; i < n; i++) step(1'b0, int'($urandom_range(0, 2047)), pick_rdy(rdy));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},    int'(bus.out_valid), 0);
    check({tag, "_base"},     int'(bus.out_base), 0);
    check({tag, "_sum"},      int'(bus.out_sum), 0);
    check({tag, "_err"},      int'(bus.out_err), 0);
    check({tag, "_overflow"}, int'(bus.overflow), 0);
    check({tag, "_desync"},   int'(bus.desync), 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    grp.delete();
    synced   = 1'b0;
    m_ovf    = 1'b0;
    m_desync = 1'b0;
    m_cnt    = 0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Monitor: compares the presented head and flags, pops on handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        check("out_valid", int'(bus.out_valid), int'(exp_q.size() != 0));
        if (bus.out_valid && exp_q.size() > 0) begin
          check("out_base", int'(bus.out_base), exp_q[0].base);
          check("out_sum",  int'(bus.out_sum),  exp_q[0].sum);
          check("out_err",  int'(bus.out_err),  int'(exp_q[0].err));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
        check("overflow", int'(bus.overflow), int'(m_ovf));
        check("desync",   int'(bus.desync),   int'(m_desync));
      end
    end
  end

  initial begin
    int kind;
    int d;
    int n;
    int w[4];
    bus.in_grant  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    synced   = 1'b0;
    m_ovf    = 1'b0;
    m_desync = 1'b0;
    m_cnt    = 0;
    checks   = 0;
    failures = 0;

    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;

    // Words before the first grant are alignment slack.
    step(1'b0, 123, 1'b1);
    step(1'b0, 77, 1'b1);

    // Clean d=5, then back-to-back 255 and 0.
    group(5, 15, 35, 40, 1);
    group(255, 765, 1785, 2040, 1);
    group(0, 0, 0, 0, 1);
    group(5, 15, 36, 40, 1);

    // Early grant abandons the d=9 group.
    step(1'b1, 9, 1'b1);
    step(1'b0, 27, 1'b1);
    group(4, 12, 28, 32, 1);
    gaps(3, 1);
    check("desync_seen", int'(bus.desync), 1);

    // Overflow with a stalled sink, then drain.
    group(1, 3, 7, 8, 0);
    group(2, 6, 14, 16, 0);
    group(3, 9, 21, 24, 0);
    step(1'b0, 0, 1'b0);
    check("overflow_seen", int'(bus.overflow), 1);
    gaps(6, 1);

    // Reset between words 1 and 2 with one record buffered.
    group(11, 33, 77, 88, 0);
    step(1'b1, 7, 1'b0);
    step(1'b0, 21, 1'b0);
    do_reset();
    gaps(2, 1);
    group(7, 21, 49, 56, 1);
    gaps(2, 1);

    // Random stream: clean, corrupted and truncated groups plus stray words.
    for (int it = 0; it < 300; it++) begin
      kind = int'($urandom_range(0, 9));
      d    = int'($urandom_range(0, 255));
      w[0] = d; w[1] = 3 * d; w[2] = 7 * d; w[3] = 8 * d;
      if (kind == 0) begin
        gaps(1, -1);
      end else if (kind == 1) begin
        n = int'($urandom_range(1, 3));
        step(1'b1, w[0], pick_rdy(-1));
        for (int k = 1; k < n; k++) step(1'b0, w[k], pick_rdy(-1));
      end else begin
        if (kind == 2) w[$urandom_range(0, 3)] = int'($urandom_range(0, 2047));
        group(w[0], w[1], w[2], w[3], -1);
      end
    end

    gaps(10, 1);
    check("drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
